// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Brief    : Wait-state memory slave with byte-lane steering and load extension.
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  size,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        error,
    output logic        busy
);

    localparam int         c_aw        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_size;
    logic        r_ready;
    logic        r_error;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic [31:0] r_mem [DEPTH_WORDS];

    // With zero wait states the response edge is the accept edge, so the
    // live bus is decoded while idle and the latched copy otherwise.
    logic        w_sel_write;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_size;
    assign w_sel_write = (r_state == c_idle) ? memory_write : r_write;
    assign w_sel_addr  = (r_state == c_idle) ? address      : r_addr;
    assign w_sel_wdata = (r_state == c_idle) ? write_data   : r_wdata;
    assign w_sel_size  = (r_state == c_idle) ? size         : r_size;

    logic [c_aw-1:0] w_index;
    logic [1:0]      w_lane;
    assign w_index = w_sel_addr[c_aw+1:2];
    assign w_lane  = w_sel_addr[1:0];

    logic w_bad_range;
    logic w_bad_size;
    logic w_misalign;
    logic w_error;
    assign w_bad_range = |w_sel_addr[31:c_aw+2];
    assign w_bad_size  = (w_sel_size == 3'b011) || (w_sel_size == 3'b110) ||
                         (w_sel_size == 3'b111) || (w_sel_size[2] && w_sel_write);
    assign w_misalign  = ((w_sel_size[1:0] == 2'b01) && w_sel_addr[0]) ||
                         ((w_sel_size[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    assign w_error     = w_bad_range || w_bad_size || w_misalign;

    logic w_enter_resp;
    assign w_enter_resp = ((r_state == c_wait) && (r_count == 4'd0)) ||
                          ((r_state == c_idle) && request && (WAIT_CYCLES == 0));

    logic [3:0]  w_be;
    logic [31:0] w_wword;
    always_comb begin
        w_be    = 4'hF;
        w_wword = w_sel_wdata;
        case (w_sel_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wword = {4{w_sel_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_lane;
                w_wword = {2{w_sel_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    logic [31:0] w_shifted;
    logic [31:0] w_load;
    assign w_shifted = r_mem[w_index] >> {w_lane, 3'b000};
    always_comb begin
        w_load = w_shifted;
        case (w_sel_size)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_idle;
            r_count <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_error <= w_error;
                r_rdata <= (w_error || w_sel_write) ? 32'd0 : w_load;
            end
            case (r_state)
                c_idle: begin
                    if (request) begin
                        r_write <= memory_write;
                        r_addr  <= address;
                        r_wdata <= write_data;
                        r_size  <= size;
                        r_busy  <= 1'b1;
                        r_count <= c_wait_load;
                        r_state <= (WAIT_CYCLES > 0) ? c_wait : c_resp;
                    end
                end
                c_wait: begin
                    if (r_count == 4'd0) begin
                        r_state <= c_resp;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                c_resp: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // RAM is never cleared; a reset on the commit edge suppresses the store.
    always_ff @(posedge clock) begin
        if (!reset && w_enter_resp && w_sel_write && !w_error) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    assign read_data = r_rdata;
    assign ready     = r_ready;
    assign error     = r_error;
    assign busy      = r_busy;

endmodule
`default_nettype wire
